// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg: shared constants, baud-select encoding and helper
// function for the UART-link clock divider.
package clock_divider_pkg;

  // Default full output periods in board-clock cycles (25 MHz, x16 oversampling)
  localparam int DIV0_DEFAULT  = 162;  // 9600 baud
  localparam int DIV1_DEFAULT  = 81;   // 19200 baud
  localparam int DIV2_DEFAULT  = 27;   // 57600 baud
  localparam int DIV3_DEFAULT  = 14;   // 115200 baud
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'd0,
    BAUD_19200  = 2'd1,
    BAUD_57600  = 2'd2,
    BAUD_115200 = 2'd3
  } baud_sel_t;

  // ceil(n/2): length of the high phase; odd periods give the extra cycle to high
  function automatic logic [31:0] ceil_half(input logic [31:0] n);
    return (n >> 32'd1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/clock_divider_period_sel.sv
// div_period_sel: selects the period for the requested baud rate and holds
// the active period and high-phase length. The held values only change on
// reset or at a period boundary, so a mid-period baudSel change never
// distorts the period in flight.
module div_period_sel
  import clock_divider_pkg::*;
#(
  parameter int DIV0  = DIV0_DEFAULT,
  parameter int DIV1  = DIV1_DEFAULT,
  parameter int DIV2  = DIV2_DEFAULT,
  parameter int DIV3  = DIV3_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [1:0]       i_baud_sel,
  output logic [CNT_W-1:0] o_cur_n,
  output logic [CNT_W-1:0] o_cur_high
);

  logic [CNT_W-1:0] w_div;
  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] r_cur_n;
  logic [CNT_W-1:0] r_cur_high;

  // Map the baud select onto its configured period
  always_comb begin
    w_div = CNT_W'(DIV0);
    case (baud_sel_t'(i_baud_sel))
      BAUD_9600:   w_div = CNT_W'(DIV0);
      BAUD_19200:  w_div = CNT_W'(DIV1);
      BAUD_57600:  w_div = CNT_W'(DIV2);
      BAUD_115200: w_div = CNT_W'(DIV3);
      default:     w_div = CNT_W'(DIV0);
    endcase
  end

  assign w_half = CNT_W'(ceil_half(32'(w_div)));

  // Latch the active period on reset or at the end of a period
  always_ff @(posedge i_clock) begin
    if (i_reset || i_load) begin
      r_cur_n    <= w_div;
      r_cur_high <= w_half;
    end else begin
      r_cur_n    <= r_cur_n;
      r_cur_high <= r_cur_high;
    end
  end

  assign o_cur_n    = r_cur_n;
  assign o_cur_high = r_cur_high;

endmodule

// File: rtl/clock_divider.sv
// clock_divider: programmable integer divider producing the UART
// oversampling clock (outClock) and a one-cycle strobe (outTick) on each
// outClock rising edge.
// Optional feature macro: CLOCK_DIVIDER_TICK_EN. When undefined, the tick
// output is tied to 0 and its flop is not built.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int DIV0  = DIV0_DEFAULT,
  parameter int DIV1  = DIV1_DEFAULT,
  parameter int DIV2  = DIV2_DEFAULT,
  parameter int DIV3  = DIV3_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic       i_in_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_baud_sel,
  output logic       o_out_clock,
  output logic       o_out_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_out_clock;
  logic [CNT_W-1:0] w_cur_n;
  logic [CNT_W-1:0] w_cur_high;
  logic             w_at_end;
  logic             w_at_high_end;
  logic             w_load;

  div_period_sel #(
    .DIV0  (DIV0),
    .DIV1  (DIV1),
    .DIV2  (DIV2),
    .DIV3  (DIV3),
    .CNT_W (CNT_W)
  ) u_period_sel (
    .i_clock    (i_in_clock),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_baud_sel (i_baud_sel),
    .o_cur_n    (w_cur_n),
    .o_cur_high (w_cur_high)
  );

  assign w_at_end      = (r_cnt == (w_cur_n - CNT_W'(1'b1)));
  assign w_at_high_end = (r_cnt == (w_cur_high - CNT_W'(1'b1)));
  // Period boundary: rising edge of outClock and reload of the period
  assign w_load        = i_enable & w_at_end;

  // Counter and divided-clock phase; disabled edges freeze everything
  always_ff @(posedge i_in_clock) begin
    if (i_reset) begin
      r_cnt       <= {CNT_W{1'b0}};
      r_out_clock <= 1'b0;
    end else if (i_enable) begin
      if (w_at_end) begin
        r_cnt       <= {CNT_W{1'b0}};
        r_out_clock <= 1'b1;
      end else if (w_at_high_end) begin
        r_cnt       <= r_cnt + CNT_W'(1'b1);
        r_out_clock <= 1'b0;
      end else begin
        r_cnt       <= r_cnt + CNT_W'(1'b1);
        r_out_clock <= r_out_clock;
      end
    end else begin
      r_cnt       <= r_cnt;
      r_out_clock <= r_out_clock;
    end
  end

  assign o_out_clock = r_out_clock;

`ifdef CLOCK_DIVIDER_TICK_EN
  logic r_out_tick;

  // One-cycle strobe coincident with each outClock rise
  always_ff @(posedge i_in_clock) begin
    if (i_reset) begin
      r_out_tick <= 1'b0;
    end else begin
      r_out_tick <= w_load;
    end
  end

  assign o_out_tick = r_out_tick;
`else
  assign o_out_tick = 1'b0;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: scoreboard bench for clock_divider. A waveform model
// (queue of future output levels, refilled one whole period at a time)
// produces the expected outputs for each edge; a monitor pops and compares.
module tb_clock_divider;
  import clock_divider_pkg::*;

`ifdef CLOCK_DIVIDER_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  typedef struct packed {
    logic c;
    logic t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] sel;
  logic       o_clk;
  logic       o_tick;

  exp_t sb_q[$];
  exp_t wave_q[$];
  logic model_clk = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #20 clk = ~clk;

  clock_divider dut (
    .i_in_clock  (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_baud_sel  (sel),
    .o_out_clock (o_clk),
    .o_out_tick  (o_tick)
  );

  function automatic int div_of(input logic [1:0] s);
    case (s)
      2'd0:    return DIV0_DEFAULT;
      2'd1:    return DIV1_DEFAULT;
      2'd2:    return DIV2_DEFAULT;
      default: return DIV3_DEFAULT;
    endcase
  endfunction

  // Drive one edge's inputs and push the outputs expected after that edge
  task automatic apply(input logic r, input logic e, input logic [1:0] s);
    exp_t x;
    int   n;
    @(negedge clk);
    rst = r;
    en  = e;
    sel = s;
    if (r) begin
      wave_q.delete();
      n = div_of(s);
      for (int i = 0; i < n - 1; i++) wave_q.push_back('{c: 1'b0, t: 1'b0});
      x = '{c: 1'b0, t: 1'b0};
    end else if (e) begin
      if (wave_q.size() == 0) begin
        n = div_of(s);
        wave_q.push_back('{c: 1'b1, t: 1'b1});
        for (int i = 0; i < (n + 1) / 2 - 1; i++) wave_q.push_back('{c: 1'b1, t: 1'b0});
        for (int i = 0; i < n / 2; i++) wave_q.push_back('{c: 1'b0, t: 1'b0});
      end
      x = wave_q.pop_front();
    end else begin
      x = '{c: model_clk, t: 1'b0};
    end
    model_clk = x.c;
    if (!TICK_ON) x.t = 1'b0;
    sb_q.push_back(x);
  endtask

  // Monitor: compare DUT outputs shortly after every rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (o_clk !== e.c || o_tick !== e.t) begin
        miscompares++;
        $display("FAIL edge_%0d outputs: outClock=%b outTick=%b, expected outClock=%b outTick=%b",
                 vectors, o_clk, o_tick, e.c, e.t);
      end
    end
  end

  // Watchdog: fail if the run does not complete in time
  initial begin
    #200000;
    miscompares++;
    $display("FAIL timeout: bench did not finish within the expected time");
    $finish;
  end

  initial begin
    logic       r;
    logic       e;
    logic [1:0] s;
    rst = 1'b1;
    en  = 1'b0;
    sel = 2'd3;

    // N=14: first rise at edge 14, then ten steady periods
    apply(1'b1, 1'b1, 2'd3);
    apply(1'b1, 1'b1, 2'd3);
    if (o_clk !== 1'b0 || o_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: outClock=%b outTick=%b, expected 0 0", o_clk, o_tick);
    end
    repeat (154) apply(1'b0, 1'b1, 2'd3);
    // switch 3->2 at cycle 5 of a period
    repeat (4) apply(1'b0, 1'b1, 2'd3);
    repeat (91) apply(1'b0, 1'b1, 2'd2);
    // enable low for 10 cycles during a high phase
    apply(1'b1, 1'b1, 2'd3);
    repeat (16) apply(1'b0, 1'b1, 2'd3);
    repeat (10) apply(1'b0, 1'b0, 2'd3);
    repeat (30) apply(1'b0, 1'b1, 2'd3);
    // reset during high phase, then odd period N=81
    repeat (3) apply(1'b0, 1'b1, 2'd3);
    apply(1'b1, 1'b1, 2'd1);
    repeat (250) apply(1'b0, 1'b1, 2'd1);

    // randomized enable / select / reset
    s = 2'd3;
    repeat (700) begin
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) s = 2'($urandom_range(0, 3));
      apply(r, e, s);
    end

    @(posedge clk);
    #5;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never compared", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
# clock_divider

Programmable integer clock divider for the two-FPGA UART link. It divides the board clock `inClock` (25 MHz in the bench, 40 ns period) down to the UART oversampling clock. It produces a near-50 %-duty divided clock `outClock` and a one-cycle strobe `outTick` aligned to each `outClock` rising edge. The UART transmitter and receiver sit downstream and consume either signal. Four divide ratios are selectable at run time, so both FPGAs can agree on a baud rate.

## Interface
- `DIV0`, default 162: full output period in `inClock` cycles for `baudSel`=0 (9600 baud ×16 at 25 MHz)
- `DIV1`, default 81: period for `baudSel`=1 (19200 ×16)
- `DIV2`, default 27: period for `baudSel`=2 (57600 ×16)
- `DIV3`, default 14: period for `baudSel`=3 (115200 ×16)
- `CNT_W`, default 16: counter width; every `DIVk` must satisfy 2 ≤ `DIVk` < 2^`CNT_W`
- `inClock`  in  1  sole clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  count enable; low freezes the divider
- `baudSel`  in  2  divide-ratio select
- `outClock`  out  1  divided clock, registered
- `outTick`  out  1  one-`inClock`-cycle strobe marking each `outClock` rising edge, registered

## Operation
- Internal state:
  - `cnt`, `CNT_W` bits.
  - `curN`: the active period, latched from `DIV[baudSel]`.
  - `curHigh`: equal to ceil(`curN`/2).
- Reset (`reset`=1 at an edge):
  - `cnt`←0, `outClock`←0, `outTick`←0.
  - `curN`←`DIV[baudSel]`; `curHigh` is recomputed from it.
  - Reset has priority over `enable`.
- Enabled edge (`enable`=1, no reset):
  - If `cnt`==`curN`−1: `cnt`←0, `outClock`←1, `outTick`←1, and `curN`←`DIV[baudSel]` (a new ratio takes effect only at a period boundary).
  - Else if `cnt`==`curHigh`−1: `cnt`←`cnt`+1, `outClock`←0, `outTick`←0.
  - Else: `cnt`←`cnt`+1; `outClock` holds; `outTick`←0.
- Disabled edge: `cnt`, `outClock` and `curN` hold; `outTick`←0.
- Duty cycle: high for ceil(N/2) cycles and low for floor(N/2) cycles. For odd N the extra cycle goes to the high phase.
- A `baudSel` change mid-period never shortens or stretches the current period and never produces a runt pulse.
- A reset in the middle of a period aborts it and drops `outClock` to 0 on the same edge.

## Timing
- After reset release with `enable` held high, the first `outClock` rising edge and the first `outTick` occur at the N-th enabled edge. The first low phase therefore lasts N cycles. Steady state is N cycles per period.
- `outTick` is high exactly one cycle per period, in the same cycle `outClock` goes to 1.
- No combinational path from any input to any output. All outputs are flops.
- `enable` low for k cycles extends the current phase by exactly k cycles.

## Configuration
- `CLOCK_DIVIDER_TICK_EN`:
  - Defined: `outTick` behaves as specified above.
  - Undefined: `outTick` is tied to constant 0, and its flop and compare are removed. `outClock` behaviour is unchanged.

## Structure
- Shared package `clock_divider_pkg` holds:
  - the default `DIV0`–`DIV3` constants and `CNT_W`;
  - a `baud_sel_t` 2-bit enum (`BAUD_9600`, `BAUD_19200`, `BAUD_57600`, `BAUD_115200`);
  - a function computing ceil(N/2).
- One sub-module is natural: `div_period_sel`, a mux from `baudSel` to the period plus the registered `curN`/`curHigh` latch.
- Counter, phase compare and output flops live in the top module.

## Test plan
- Reset, then `enable`=1, `baudSel`=3 (N=14) -> first `outClock` rise at edge 14; then 7 cycles high, 7 low, with a 14-cycle period repeated for 10 periods.
- `baudSel`=1 (N=81, odd) -> 41 cycles high, 40 low; `outTick` exactly one cycle wide at each rise.
- `baudSel` switched 3→2 at cycle 5 of a period -> that period remains 14 cycles; the next and following periods are 27 cycles (14 high / 13 low).
- `enable` dropped for 10 cycles during a high phase -> that high phase lasts 17 cycles; `outTick` stays 0 while disabled.
- `reset` asserted during the high phase -> `outClock`=0 and `cnt`=0 after that edge; the next rise comes N enabled cycles after release.
- Build without `CLOCK_DIVIDER_TICK_EN` -> `outTick` stays 0 throughout; `outClock` waveform is identical to the default build.
